// File: rtl/stage7_if.sv
// Operand/result handshake bundle for the stage7 normalizing divider.
// The master side supplies operands and consumes results; the slave side is the divider.
interface stage7_if #(
    parameter int NUM_W = 16,
    parameter int DEN_W = 8,
    parameter int OUT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [DEN_W-1:0] a;
    logic [NUM_W-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] pix;
    logic             sat;
    logic             div_zero;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, pix, sat, div_zero
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, pix, sat, div_zero
    );
endinterface

// File: rtl/stage7.sv
// Multi-cycle restoring divider that normalizes a weighted pixel sum b by its
// weight sum a, producing floor(b/a) clamped to OUT_W bits with sat/div_zero flags.
module stage7 #(
    parameter int NUM_W = 16,
    parameter int DEN_W = 8,
    parameter int OUT_W = 8
) (
    input  logic     clk,
    input  logic     rst,
    stage7_if.slave  bus
);
    localparam int CNT_W = (NUM_W > 1) ? $clog2(NUM_W) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [NUM_W-1:0]   rem_r;
    logic [NUM_W-1:0]   dvd_r;
    logic [NUM_W-1:0]   quo_r;
    logic [DEN_W-1:0]   den_r;
    logic [OUT_W-1:0]   pix_r;
    logic               sat_r;
    logic               div_zero_r;
    logic               in_ready_r;
    logic               out_valid_r;

    logic [NUM_W:0]     rem_shift_s;
    logic [NUM_W:0]     trial_s;
    logic               qbit_s;
    logic [NUM_W-1:0]   rem_next_s;
    logic [NUM_W-1:0]   quo_next_s;
    logic               sat_s;
    logic [OUT_W-1:0]   pix_s;
    logic               last_step_s;

    // One restoring step: the extra top bit of the trial difference acts as the borrow.
    always_comb begin
        rem_shift_s = {rem_r, dvd_r[NUM_W-1]};
        trial_s     = rem_shift_s - (NUM_W+1)'(den_r);
        qbit_s      = ~trial_s[NUM_W];
        if (qbit_s) begin
            rem_next_s = trial_s[NUM_W-1:0];
        end else begin
            rem_next_s = rem_shift_s[NUM_W-1:0];
        end
        quo_next_s  = {quo_r[NUM_W-2:0], qbit_s};
        sat_s       = (quo_next_s > NUM_W'({OUT_W{1'b1}}));
        if (sat_s) begin
            pix_s = {OUT_W{1'b1}};
        end else begin
            pix_s = OUT_W'(quo_next_s);
        end
        last_step_s = (cnt_r == CNT_W'(NUM_W - 1));
    end

    // Control FSM, datapath registers and registered handshake/result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            rem_r       <= '0;
            dvd_r       <= '0;
            quo_r       <= '0;
            den_r       <= '0;
            pix_r       <= '0;
            sat_r       <= 1'b0;
            div_zero_r  <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.in_valid) begin
                        den_r      <= bus.a;
                        dvd_r      <= bus.b;
                        rem_r      <= '0;
                        quo_r      <= '0;
                        cnt_r      <= '0;
                        in_ready_r <= 1'b0;
                        if (bus.a == '0) begin
                            pix_r       <= '0;
                            sat_r       <= 1'b0;
                            div_zero_r  <= 1'b1;
                            out_valid_r <= 1'b1;
                            state_r     <= DONE;
                        end else begin
                            state_r     <= DIV;
                        end
                    end
                end
                DIV: begin
                    rem_r <= rem_next_s;
                    dvd_r <= {dvd_r[NUM_W-2:0], 1'b0};
                    quo_r <= quo_next_s;
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (last_step_s) begin
                        pix_r       <= pix_s;
                        sat_r       <= sat_s;
                        div_zero_r  <= 1'b0;
                        out_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end
                end
                DONE: begin
                    // Results stay frozen here until the consumer takes them.
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.pix       = pix_r;
    assign bus.sat       = sat_r;
    assign bus.div_zero  = div_zero_r;
endmodule

// File: tb/tb_stage7.sv
// Self-checking bench for stage7: directed scenarios plus randomized operands
// checked against an arithmetic reference of floor(b/a) with clamping.
module tb_stage7;
    localparam int NUM_W = 16;
    localparam int DEN_W = 8;
    localparam int OUT_W = 8;
    localparam int LAT   = NUM_W + 1;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   cyc;

    stage7_if #(.NUM_W(NUM_W), .DEN_W(DEN_W), .OUT_W(OUT_W)) bus ();

    stage7 #(.NUM_W(NUM_W), .DEN_W(DEN_W), .OUT_W(OUT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {div_zero, sat, pix} from plain integer arithmetic.
    function automatic logic [OUT_W+1:0] ref_model(input int unsigned av, input int unsigned bv);
        int unsigned q;
        if (av == 0) return {1'b1, 1'b0, {OUT_W{1'b0}}};
        q = bv / av;
        if (q > 255) return {1'b0, 1'b1, 8'hFF};
        return {1'b0, 1'b0, q[OUT_W-1:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Offers one operand pair, then waits (bounded) for out_valid; stray inputs are
    // scrambled while the block is busy.
    task automatic run_op(input logic [DEN_W-1:0] av, input logic [NUM_W-1:0] bv,
                          output int lat, output logic [OUT_W+1:0] res, output logic rdy);
        bus.a        = av;
        bus.b        = bv;
        bus.in_valid = 1'b1;
        rdy          = bus.in_ready;
        tick();
        lat = 1;
        while (!bus.out_valid && lat < 60) begin
            bus.in_valid = 1'($urandom);
            bus.a        = DEN_W'($urandom);
            bus.b        = NUM_W'($urandom);
            tick();
            lat++;
        end
        bus.in_valid = 1'b0;
        res = {bus.div_zero, bus.sat, bus.pix};
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.a = '0;
        bus.b = '0;
        tick();
        tick();
        total++;
        if ({bus.in_ready, bus.out_valid, bus.div_zero, bus.sat, bus.pix} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            bad++;
            $display("FAIL reset_state: got rdy=%b vld=%b dz=%b sat=%b pix=%0d want rdy=1 vld=0 dz=0 sat=0 pix=0",
                     bus.in_ready, bus.out_valid, bus.div_zero, bus.sat, bus.pix);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int lat;
        logic [OUT_W+1:0] res;
        logic rdy;
        bus.out_ready = 1'b1;
        run_op(8'd10, 16'd1000, lat, res, rdy);
        total++;
        if (rdy !== 1'b1) begin
            bad++;
            $display("FAIL basic_ready: got %b want 1", rdy);
        end
        total++;
        if (lat !== LAT) begin
            bad++;
            $display("FAIL basic_latency: got %0d want %0d", lat, LAT);
        end
        total++;
        if (res !== {1'b0, 1'b0, 8'd100}) begin
            bad++;
            $display("FAIL basic_result: got %h want %h", res, {1'b0, 1'b0, 8'd100});
        end
        tick();
        total++;
        if ({bus.in_ready, bus.out_valid, bus.pix} !== {1'b1, 1'b0, 8'd100}) begin
            bad++;
            $display("FAIL basic_after_done: got rdy=%b vld=%b pix=%0d want rdy=1 vld=0 pix=100",
                     bus.in_ready, bus.out_valid, bus.pix);
        end
    endtask

    task automatic test_trunc_sat();
        int lat;
        logic [OUT_W+1:0] res;
        logic rdy;
        run_op(8'd2, 16'd7, lat, res, rdy);
        total++;
        if (res !== {1'b0, 1'b0, 8'd3} || lat !== LAT) begin
            bad++;
            $display("FAIL truncate: got res=%h lat=%0d want res=%h lat=%0d", res, lat, {1'b0, 1'b0, 8'd3}, LAT);
        end
        tick();
        run_op(8'd1, 16'hFFFF, lat, res, rdy);
        total++;
        if (res !== {1'b0, 1'b1, 8'hFF} || lat !== LAT) begin
            bad++;
            $display("FAIL saturate: got res=%h lat=%0d want res=%h lat=%0d", res, lat, {1'b0, 1'b1, 8'hFF}, LAT);
        end
        tick();
    endtask

    task automatic test_div_zero();
        int lat;
        logic [OUT_W+1:0] res;
        logic rdy;
        run_op(8'd0, 16'd500, lat, res, rdy);
        total++;
        if (lat !== 1 || res !== {1'b1, 1'b0, 8'd0}) begin
            bad++;
            $display("FAIL div_zero: got res=%h lat=%0d want res=%h lat=1", res, lat, {1'b1, 1'b0, 8'd0});
        end
        tick();
    endtask

    task automatic test_backpressure();
        int lat;
        logic [OUT_W+1:0] res;
        logic rdy;
        int errs;
        bus.out_ready = 1'b0;
        run_op(8'd4, 16'd400, lat, res, rdy);
        total++;
        if (lat !== LAT || res !== {1'b0, 1'b0, 8'd100}) begin
            bad++;
            $display("FAIL bp_result: got res=%h lat=%0d want res=%h lat=%0d", res, lat, {1'b0, 1'b0, 8'd100}, LAT);
        end
        errs = 0;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'($urandom);
            bus.a        = DEN_W'($urandom);
            bus.b        = NUM_W'($urandom);
            tick();
            if ({bus.out_valid, bus.in_ready, bus.div_zero, bus.sat, bus.pix} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'd100})
                errs++;
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL bp_hold: got %0d unstable cycles want 0 (last vld=%b rdy=%b pix=%0d)",
                     errs, bus.out_valid, bus.in_ready, bus.pix);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        total++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
            bad++;
            $display("FAIL bp_release: got rdy=%b vld=%b want rdy=1 vld=0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_mid_reset();
        int lat;
        int seen;
        logic [OUT_W+1:0] res;
        logic rdy;
        bus.a        = 8'd3;
        bus.b        = 16'd900;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        seen = 0;
        for (int i = 1; i < 8; i++) begin
            tick();
            if (bus.out_valid) seen++;
        end
        rst = 1'b1;
        tick();
        if (bus.out_valid) seen++;
        total++;
        if ({bus.in_ready, bus.out_valid, bus.div_zero, bus.sat, bus.pix} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            bad++;
            $display("FAIL midrst_state: got rdy=%b vld=%b dz=%b sat=%b pix=%0d want 1 0 0 0 0",
                     bus.in_ready, bus.out_valid, bus.div_zero, bus.sat, bus.pix);
        end
        rst = 1'b0;
        run_op(8'd5, 16'd250, lat, res, rdy);
        total++;
        if (seen != 0 || lat !== LAT || res !== {1'b0, 1'b0, 8'd50}) begin
            bad++;
            $display("FAIL midrst_next: got stray=%0d lat=%0d res=%h want stray=0 lat=%0d res=%h",
                     seen, lat, res, LAT, {1'b0, 1'b0, 8'd50});
        end
        tick();
    endtask

    task automatic test_random();
        int lat;
        int want_lat;
        logic [OUT_W+1:0] res;
        logic [OUT_W+1:0] want;
        logic rdy;
        logic [DEN_W-1:0] av;
        logic [NUM_W-1:0] bv;
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 3))
                0:       av = 8'd0;
                1:       av = DEN_W'($urandom_range(1, 8));
                default: av = DEN_W'($urandom_range(1, 255));
            endcase
            bv       = NUM_W'($urandom);
            want     = ref_model(int'(av), int'(bv));
            want_lat = (av == 0) ? 1 : LAT;
            run_op(av, bv, lat, res, rdy);
            total++;
            if (rdy !== 1'b1 || lat !== want_lat || res !== want) begin
                bad++;
                $display("FAIL random_op a=%0d b=%0d: got rdy=%b lat=%0d res=%h want rdy=1 lat=%0d res=%h",
                         av, bv, rdy, lat, res, want_lat, want);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [OUT_W+1:0] expq[$];
        logic [OUT_W+1:0] want;
        int acc_cyc;
        int results;
        int n_acc;
        int limit;
        acc_cyc = -1;
        results = 0;
        n_acc   = 0;
        limit   = cyc + 300;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        while (results < 6 && cyc < limit) begin
            if (bus.out_valid) begin
                want = (expq.size() > 0) ? expq.pop_front() : 10'h3FF;
                total++;
                if ({bus.div_zero, bus.sat, bus.pix} !== want) begin
                    bad++;
                    $display("FAIL b2b_result %0d: got %h want %h", results, {bus.div_zero, bus.sat, bus.pix}, want);
                end
                results++;
            end
            if (bus.in_ready) begin
                if (n_acc[0]) begin
                    bus.a = DEN_W'($urandom_range(1, 3));
                end else begin
                    bus.a = DEN_W'($urandom_range(50, 255));
                end
                bus.b = NUM_W'($urandom);
                expq.push_back(ref_model(int'(bus.a), int'(bus.b)));
                if (acc_cyc >= 0) begin
                    total++;
                    if (cyc - acc_cyc !== NUM_W + 2) begin
                        bad++;
                        $display("FAIL b2b_spacing: got %0d want %0d", cyc - acc_cyc, NUM_W + 2);
                    end
                end
                acc_cyc = cyc;
                n_acc++;
            end
            tick();
        end
        bus.in_valid = 1'b0;
        total++;
        if (results < 6) begin
            bad++;
            $display("FAIL b2b_timeout: got %0d results want 6", results);
        end
        while (!bus.in_ready && cyc < limit + 40) tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        cyc   = 0;
        test_reset();
        test_basic();
        test_trunc_sat();
        test_div_zero();
        test_backpressure();
        test_mid_reset();
        test_random();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
